// File: rtl/riscv_pkg.sv
// Shared core types and the data-memory responder's state, response and
// request-field definitions.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int XBYTES = XLEN / 8;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rdata;
    logic            err;
  } dmem_rsp_t;

  // LSU request fields, one-to-one with the responder request inputs.
  typedef struct packed {
    logic              re;
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [XBYTES-1:0] wstrb;
  } lsu_out_t;

  // Byte address to word index; callers keep only the low bits they need.
  function automatic logic [XLEN-3:0] dmem_word_idx(input logic [XLEN-1:0] addr);
    return addr[XLEN-1:2];
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// LSU-to-data-memory request/response bundle.
interface dmem_responder_if;
  import riscv_pkg::*;

  logic              mem_re;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XBYTES-1:0] mem_wstrb;
  logic              mem_ready;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  modport master (
    output mem_re, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  mem_re, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port byte-strobed word RAM with registered read data; kept separate
// so it can be swapped for an SRAM macro.
module dmem_array
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [XBYTES-1:0] wstrb,
  input  logic [AW-1:0]     idx,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem_r [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_r;

  // Storage update, one byte lane per strobe bit; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < XBYTES; i++) begin
        if (wstrb[i]) begin
          mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read capture doubles as the response hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {XLEN{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[idx];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: ready/response handshake with LATENCY wait states.
// Optional DMEM_RANGE_CHECK_EN flags addresses beyond the array as errors.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  lsu_out_t        req_s;
  logic            req_valid_s;
  logic            ready_s;
  logic            accept_s;
  logic            illegal_s;
  logic            range_err_s;
  logic            err_s;
  logic            wr_en_s;
  logic            rd_en_s;
  logic [XLEN-3:0] word_full_s;
  logic [AW-1:0]   idx_s;
  logic [XLEN-1:0] hold_s;
  logic            unused_s;

  dmem_state_t     state_r;
  logic [CW-1:0]   cnt_r;
  logic            rd_r;
  logic            err_r;
  dmem_rsp_t       rsp_r;

  assign req_s = '{re: bus.mem_re, we: bus.mem_we, addr: bus.mem_addr,
                   wdata: bus.mem_wdata, wstrb: bus.mem_wstrb};

  assign req_valid_s = req_s.re | req_s.we;
  assign ready_s     = (state_r == DMEM_IDLE);
  assign accept_s    = req_valid_s & ready_s;

  assign word_full_s = dmem_word_idx(req_s.addr);
  assign idx_s       = word_full_s[AW-1:0];

`ifdef DMEM_RANGE_CHECK_EN
  assign range_err_s = ((req_s.addr >> (AW + 2)) != {XLEN{1'b0}});
`else
  assign range_err_s = 1'b0;
`endif
  assign unused_s = ^{word_full_s[XLEN-3:AW], req_s.addr[1:0]};

  // Failed requests neither touch storage nor return data.
  assign illegal_s = req_s.re & req_s.we;
  assign err_s     = illegal_s | range_err_s;
  assign wr_en_s   = accept_s & req_s.we & ~err_s;
  assign rd_en_s   = accept_s & req_s.re & ~err_s;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en_s),
    .re    (rd_en_s),
    .wstrb (req_s.wstrb),
    .idx   (idx_s),
    .wdata (req_s.wdata),
    .rdata (hold_s)
  );

  // Request FSM; response fields are loaded on entry to RESP so they are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= DMEM_IDLE;
      cnt_r   <= {CW{1'b0}};
      rd_r    <= 1'b0;
      err_r   <= 1'b0;
      rsp_r   <= '{valid: 1'b0, rdata: {XLEN{1'b0}}, err: 1'b0};
    end else begin
      case (state_r)
        DMEM_IDLE: begin
          if (accept_s) begin
            state_r <= DMEM_WAIT;
            cnt_r   <= CW'(LATENCY - 1);
            rd_r    <= req_s.re & ~err_s;
            err_r   <= err_s;
          end else begin
            state_r <= DMEM_IDLE;
          end
          rsp_r <= '{valid: 1'b0, rdata: {XLEN{1'b0}}, err: 1'b0};
        end
        DMEM_WAIT: begin
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= DMEM_RESP;
            rsp_r   <= '{valid: 1'b1,
                         rdata: rd_r ? hold_s : {XLEN{1'b0}},
                         err:   err_r};
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        DMEM_RESP: begin
          state_r <= DMEM_IDLE;
          rsp_r   <= '{valid: 1'b0, rdata: {XLEN{1'b0}}, err: 1'b0};
        end
        default: begin
          state_r <= DMEM_IDLE;
          cnt_r   <= {CW{1'b0}};
          rsp_r   <= '{valid: 1'b0, rdata: {XLEN{1'b0}}, err: 1'b0};
        end
      endcase
    end
  end

  assign bus.mem_ready = ready_s;
  assign bus.rsp_valid = rsp_r.valid;
  assign bus.rsp_rdata = rsp_r.rdata;
  assign bus.rsp_err   = rsp_r.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with LATENCY 1, 2 and 3.
module tb_dmem_responder;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        re    [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  wstrb [3];
  logic        rdy   [3];
  logic        vld   [3];
  logic [31:0] rdat  [3];
  logic        rerr  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder_if bus ();
    assign bus.mem_re    = re[g];
    assign bus.mem_we    = we[g];
    assign bus.mem_addr  = addr[g];
    assign bus.mem_wdata = wdata[g];
    assign bus.mem_wstrb = wstrb[g];
    assign rdy[g]  = bus.mem_ready;
    assign vld[g]  = bus.rsp_valid;
    assign rdat[g] = bus.rsp_rdata;
    assign rerr[g] = bus.rsp_err;
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(g + 1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request from IDLE (called at a negedge), return response and latency in negedges.
  task automatic do_req(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s,
                        output logic [31:0] rd, output logic er, output int lat);
    re[d] = r; we[d] = w; addr[d] = a; wdata[d] = wd; wstrb[d] = s;
    @(posedge clk);
    #1;
    re[d] = 1'b0; we[d] = 1'b0;
    lat = 0; rd = 32'hxxxx_xxxx; er = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (vld[1'b0 ? 0 : d]) begin
        lat = i; rd = rdat[d]; er = rerr[d];
        break;
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  s;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];

  initial begin : main
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          rdy_low, pulses;
    logic        rdy5, rdy6, seen;
    logic [31:0] pulse_data;
    logic        range_en;
`ifdef DMEM_RANGE_CHECK_EN
    range_en = 1'b1;
`else
    range_en = 1'b0;
`endif
    for (int d = 0; d < 3; d++) begin
      re[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0; wstrb[d] = 4'h0;
    end

    vecs[0]  = '{1'b0, 1'b1, 32'h10,   32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h20,   32'h1122_3344, 4'hF, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h20,   32'hAA00_00BB, 4'h9, 32'h0,         1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h20,   32'h0,         4'h0, 32'hAA22_33BB, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h20,   32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h20,   32'h0,         4'h0, 32'hAA22_33BB, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h30,   32'h1234_5678, 4'hF, 32'h0,         1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h30,   32'h5555_5555, 4'hF, 32'h0,         1'b1};
    vecs[9]  = '{1'b1, 1'b0, 32'h30,   32'h0,         4'h0, 32'h1234_5678, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h13,   32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'h0,    32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 1'b1, 32'h1000, 32'h0BAD_C0DE, 4'hF, 32'h0,         range_en};
    vecs[13] = '{1'b1, 1'b0, 32'h0,    32'h0,         4'h0,
                 range_en ? 32'hCAFE_F00D : 32'h0BAD_C0DE, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 32'h1010, 32'h0,         4'h0,
                 range_en ? 32'h0 : 32'hDEAD_BEEF, range_en};

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_valid[%0d]", d), {31'h0, vld[d]}, 32'h0);
      chk($sformatf("rst_rdata[%0d]", d), rdat[d], 32'h0);
      chk($sformatf("rst_err[%0d]", d), {31'h0, rerr[d]}, 32'h0);
      chk($sformatf("rst_ready[%0d]", d), {31'h0, rdy[d]}, 32'h1);
    end

    // LATENCY=1 write then read
    do_req(0, 1'b0, 1'b1, 32'h44, 32'h0102_0304, 4'hF, rd, er, lat);
    chk("l1_wr_lat", lat, 32'd2);
    do_req(0, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0, rd, er, lat);
    chk("l1_rd_lat", lat, 32'd2);
    chk("l1_rd_data", rd, 32'h0102_0304);

    // Vector table on the LATENCY=2 instance
    foreach (vecs[i]) begin
      do_req(1, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].s, rd, er, lat);
      chk($sformatf("vec%0d_lat", i), lat, 32'd3);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
    end

    // Handshake on LATENCY=3: hold mem_re across two acceptances
    do_req(2, 1'b0, 1'b1, 32'h40, 32'h0000_0077, 4'hF, rd, er, lat);
    chk("l3_wr_lat", lat, 32'd4);
    re[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h40;
    rdy_low = 0; pulses = 0; pulse_data = 32'h0; rdy5 = 1'b0; rdy6 = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n <= 4 && !rdy[2]) rdy_low++;
      if (n <= 5 && vld[2]) begin
        pulses++;
        pulse_data = rdat[2];
      end
      if (n == 5) rdy5 = rdy[2];
      if (n == 6) rdy6 = rdy[2];
    end
    re[2] = 1'b0;
    chk("hs_ready_low", rdy_low, 32'd4);
    chk("hs_pulses", pulses, 32'd1);
    chk("hs_rdata", pulse_data, 32'h0000_0077);
    chk("hs_ready_after_resp", {31'h0, rdy5}, 32'h1);
    chk("hs_second_accept", {31'h0, rdy6}, 32'h0);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = vld[2];
    end
    chk("hs_second_rsp", {31'h0, seen}, 32'h1);
    @(negedge clk);

    // Reset during WAIT on LATENCY=2: no response, accepted write stays committed
    re[1] = 1'b0; we[1] = 1'b1; addr[1] = 32'h50; wdata[1] = 32'h600D_F00D; wstrb[1] = 4'hF;
    @(posedge clk);
    #1;
    we[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (vld[1]) pulses++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {31'h0, rdy[1]}, 32'h1);
    chk("mid_rst_rdata", rdat[1], 32'h0);
    repeat (4) begin
      if (vld[1]) pulses++;
      @(negedge clk);
    end
    chk("mid_rst_no_valid", pulses, 32'd0);
    do_req(1, 1'b1, 1'b0, 32'h50, 32'h0, 4'h0, rd, er, lat);
    chk("mid_rst_wr_kept", rd, 32'h600D_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
